gift_128_bus_ingress: RTL and testbench
=======================================

Name: gift_128_bus_ingress

Overview:
Upstream feeder for gift_enc_core_controller. It accepts key and plaintext as a stream of 32-bit words with a valid/ready handshake and assembles each stream into a 128-bit block. It issues key_input_valid or data_input_valid pulses to the core. It tracks core occupancy from cipher_out_valid, so a new data block, or a key reload, is never presented while an encryption is in flight. One assembly buffer lets the next block fill while the core is busy.

Parameters:
WORD_W, 32, stream word width; must divide 128 (BEATS = 128/WORD_W).
MSW_FIRST, 1, 1: first beat lands in [127:128-WORD_W]; 0: first beat lands in [WORD_W-1:0].
KEY_GAP, 2, cycles s_ready is held low after a key issue (core key-load settle).
CORE_TIMEOUT, 256, max cycles from data issue to cipher_out_valid rise.

Ports:
clk_i  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
s_valid  in  1  stream word valid
s_ready  out  1  stream word accepted when s_valid&&s_ready
s_data  in  WORD_W  stream word
s_is_key  in  1  word belongs to a key block (1) or data block (0)
s_last  in  1  final word of block
key_input_valid  out  1  one-cycle key load pulse to core
key_input  out  128  registered key, stable from pulse until next key issue
data_input_valid  out  1  one-cycle data start pulse to core
data_input  out  128  registered plaintext, stable until next data issue
cipher_out_valid  in  1  core completion; rising edge = core done
err_o  out  3  sticky: [0] framing, [1] data-without-key, [2] core timeout
err_clr  in  1  clears err_o (set wins if same cycle)
blk_cnt  out  16  data blocks issued, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): s_ready=0, pulses=0, key_input=0, data_input=0, err_o=0, blk_cnt=0, key_loaded=0, state=IDLE. s_ready=1 from the first clock after release. Reset mid-block or mid-encryption discards everything.
- Assembly: beat counter 0..BEATS-1. The block type is latched on beat 0.
- Framing error (err_o[0]) on any of these: s_is_key differs from the latched type mid-block; s_last=1 before beat BEATS-1; s_last=0 on beat BEATS-1. The partial block and the offending word are discarded and the counter returns to 0.
- s_ready=1 in IDLE/COLLECT while the assembly buffer is not complete. It is low while a completed block waits for issue, and during KEY_GAP.
- Core state: core_busy is set on a data issue. It clears on the cycle a rising edge of cipher_out_valid is detected (registered previous value), or on timeout.
- Issue rule: a completed block issues in the cycle after (block complete && !core_busy). If both become true in the same cycle, issue happens the next cycle (latency 1).
  - Final beat accepted at cycle N with the core idle -> pulse at N+1 and s_ready=1 at N+1 for data; for a key, s_ready=1 at N+1+KEY_GAP.
- Key issue: key_input <= buffer, key_input_valid=1 for one cycle, key_loaded=1. Keys are never issued while core_busy.
- Data issue with key_loaded=0: the block is dropped, err_o[1] is set, and no pulse is generated.
- Data issue with key_loaded=1: data_input <= buffer, data_input_valid=1 for one cycle, blk_cnt+1, core_busy=1, timeout counter loaded.
- Timeout: core_busy held CORE_TIMEOUT cycles with no rising edge -> err_o[2] set, core_busy cleared, state returns to IDLE. The pending assembled block is kept.
- FSM states: IDLE -> COLLECT (beat 0 accepted) -> PEND (block complete) -> ISSUE_KEY | ISSUE_DATA -> KEY_GAP | IDLE. A framing error at any COLLECT beat -> IDLE. WAIT_CORE is an orthogonal flag and does not block COLLECT.
- Only one pulse output is high in any cycle. err_o bits are sticky until err_clr.

Decomposition:
- Package gift_128_pkg: GIFT_BLK_W=128, BEATS function, FSM state enum, ERR_FRAME/ERR_NOKEY/ERR_TMO bit indices.
- Sub-module gift_128_word_asm: beat counter, shift/placement register, framing check. It outputs blk_done, blk_is_key and frame_err.

Test Plan:
- Key words 01234567,89abcdef,01234567,89abcdef (s_is_key=1, last on beat 3) -> key_input=0123456789abcdef0123456789abcdef, single key_input_valid pulse one cycle after beat 3, s_ready low for 2 cycles.
- Same 4 words as data after the key -> data_input_valid pulse, data_input equals the same value, blk_cnt=1. Feed a second data block while core_busy -> s_ready low after 4 beats; data pulse occurs one cycle after the cipher_out_valid rise.
- Data block before any key -> no data_input_valid, err_o=3'b010. err_clr -> err_o=0.
- s_last asserted on beat 1, then s_is_key toggled on beat 2 of a new block -> err_o[0]=1 both times, no pulses, the next clean key block loads correctly.
- cipher_out_valid held 0 after a data issue -> err_o[2] set exactly 256 cycles after issue, and the next data block issues.
- Reset asserted mid-block (beat 2) and again during core_busy -> all outputs zero asynchronously. After release, a full key+data sequence gives blk_cnt=1.

Source files
------------

// File: rtl/gift_128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gift_128_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               GIFT-128 bus ingress block.
// Revision    : 1.0 - initial release
// ============================================================================
package gift_128_pkg;

    localparam int GIFT_BLK_W = 128;

    // Bit positions inside the sticky error vector
    localparam int ERR_FRAME = 0;
    localparam int ERR_NOKEY = 1;
    localparam int ERR_TMO   = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COLLECT    = 3'd1,
        ST_PEND       = 3'd2,
        ST_ISSUE_KEY  = 3'd3,
        ST_ISSUE_DATA = 3'd4,
        ST_KEY_GAP    = 3'd5
    } state_t;

    // Number of stream beats that make up one 128-bit block
    function automatic int beats(input int word_w);
        return GIFT_BLK_W / word_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gift_128_word_asm.sv
`default_nettype none
// ============================================================================
// Module      : gift_128_word_asm
// Description : Beat counter, word placement and framing check. Presents the
//               block including the word on the bus so a completed block can
//               be consumed in the same cycle as its final beat.
// Revision    : 1.0 - initial release
// ============================================================================
module gift_128_word_asm
    import gift_128_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter bit MSW_FIRST = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  accept,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_is_key,
    input  logic                  s_last,
    output logic [GIFT_BLK_W-1:0] blk,
    output logic                  blk_done,
    output logic                  blk_is_key,
    output logic                  frame_err
);
    localparam int              BEATS     = beats(WORD_W);
    localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_type;
    logic [GIFT_BLK_W-1:0] r_buf;
    logic [CNT_W-1:0]      w_slot;
    logic                  w_first;
    logic                  w_last_beat;

    generate
        if (MSW_FIRST) begin : g_msw_first
            assign w_slot = LAST_BEAT - r_cnt;
        end else begin : g_lsw_first
            assign w_slot = r_cnt;
        end
    endgenerate

    assign w_first     = (r_cnt == '0);
    assign w_last_beat = (r_cnt == LAST_BEAT);
    assign blk_is_key  = w_first ? s_is_key : r_type;
    assign frame_err   = accept && ((!w_first && (s_is_key != r_type)) || (s_last != w_last_beat));
    assign blk_done    = accept && w_last_beat && !frame_err;

    // Merge the word on the bus into the held buffer at its slot
    always_comb begin
        blk = r_buf;
        if (accept) begin
            blk[int'(w_slot)*WORD_W +: WORD_W] = s_data;
        end
    end

    // Beat counter, block type latch and buffer update
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_type <= 1'b0;
            r_buf  <= '0;
        end else if (accept) begin
            if (w_first) begin
                r_type <= s_is_key;
            end
            if (frame_err || w_last_beat) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (!frame_err) begin
                r_buf <= blk;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gift_128_bus_ingress.sv
`default_nettype none
// ============================================================================
// Module      : gift_128_bus_ingress
// Description : Stream-to-block feeder for the GIFT-128 core. Assembles key
//               and plaintext blocks, issues load pulses and keeps data and
//               key reloads away from an encryption in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module gift_128_bus_ingress
    import gift_128_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter bit MSW_FIRST    = 1'b1,
    parameter int KEY_GAP      = 2,
    parameter int CORE_TIMEOUT = 256
) (
    input  logic                  clk_i,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_is_key,
    input  logic                  s_last,
    output logic                  key_input_valid,
    output logic [GIFT_BLK_W-1:0] key_input,
    output logic                  data_input_valid,
    output logic [GIFT_BLK_W-1:0] data_input,
    input  logic                  cipher_out_valid,
    output logic [2:0]            err_o,
    input  logic                  err_clr,
    output logic [15:0]           blk_cnt
);
    localparam int GAP_W = $clog2(KEY_GAP + 2);
    localparam int TMO_W = $clog2(CORE_TIMEOUT + 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_run;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_busy;
    logic [TMO_W-1:0]      r_tmo;
    logic                  r_cov_q;
    logic                  r_key_loaded;
    logic                  r_pend_key;
    logic [GIFT_BLK_W-1:0] r_key;
    logic [GIFT_BLK_W-1:0] r_data;
    logic [2:0]            r_err;
    logic [15:0]           r_blk_cnt;

    logic [GIFT_BLK_W-1:0] w_blk;
    logic w_blk_done, w_blk_is_key, w_frame_err;
    logic w_accept, w_rise, w_free, w_tmo;
    logic w_issue, w_issue_key, w_go_key, w_go_data, w_drop;
    logic [2:0] w_err_set;

    gift_128_word_asm #(
        .WORD_W    (WORD_W),
        .MSW_FIRST (MSW_FIRST)
    ) u_asm (
        .clk_i      (clk_i),
        .reset      (reset),
        .accept     (w_accept),
        .s_data     (s_data),
        .s_is_key   (s_is_key),
        .s_last     (s_last),
        .blk        (w_blk),
        .blk_done   (w_blk_done),
        .blk_is_key (w_blk_is_key),
        .frame_err  (w_frame_err)
    );

    // Stalled while a finished block waits or the core settles a new key
    assign s_ready  = r_run && (r_state != ST_PEND) && (r_gap == '0);
    assign w_accept = s_valid && s_ready;

    // A rising completion edge frees the core in the cycle it is seen
    assign w_rise = cipher_out_valid && !r_cov_q;
    assign w_free = !r_busy || w_rise;
    assign w_tmo  = r_busy && !w_rise && (r_tmo == '0);

    assign w_issue     = ((r_state == ST_PEND) || w_blk_done) && w_free;
    assign w_issue_key = (r_state == ST_PEND) ? r_pend_key : w_blk_is_key;
    assign w_go_key    = w_issue && w_issue_key;
    assign w_go_data   = w_issue && !w_issue_key && r_key_loaded;
    assign w_drop      = w_issue && !w_issue_key && !r_key_loaded;

    assign key_input_valid  = (r_state == ST_ISSUE_KEY);
    assign data_input_valid = (r_state == ST_ISSUE_DATA);
    assign key_input        = r_key;
    assign data_input       = r_data;
    assign err_o            = r_err;
    assign blk_cnt          = r_blk_cnt;

    // State register; r_run holds s_ready low until the first clock after reset
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    // Next-state: issue decisions first, then assembly progress, then drain
    always_comb begin
        w_next = r_state;
        if (w_go_key) begin
            w_next = ST_ISSUE_KEY;
        end else if (w_go_data) begin
            w_next = ST_ISSUE_DATA;
        end else if (w_drop || w_frame_err) begin
            w_next = ST_IDLE;
        end else if (w_blk_done) begin
            w_next = ST_PEND;
        end else if (w_accept) begin
            w_next = ST_COLLECT;
        end else begin
            case (r_state)
                ST_ISSUE_KEY, ST_KEY_GAP: w_next = (r_gap > GAP_W'(1)) ? ST_KEY_GAP : ST_IDLE;
                ST_ISSUE_DATA:            w_next = ST_IDLE;
                default:                  w_next = r_state;
            endcase
        end
    end

    // Issue datapath: output registers, key status, pending type, gap timer
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_key        <= '0;
            r_data       <= '0;
            r_blk_cnt    <= '0;
            r_key_loaded <= 1'b0;
            r_pend_key   <= 1'b0;
            r_gap        <= '0;
        end else begin
            if (w_blk_done) begin
                r_pend_key <= w_blk_is_key;
            end
            if (w_go_key) begin
                r_key        <= w_blk;
                r_key_loaded <= 1'b1;
                r_gap        <= GAP_W'(KEY_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
            if (w_go_data) begin
                r_data    <= w_blk;
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
        end
    end

    // Core occupancy with completion-edge detect and watchdog
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_cov_q <= 1'b0;
        end else begin
            r_cov_q <= cipher_out_valid;
            if (w_go_data) begin
                r_busy <= 1'b1;
                r_tmo  <= TMO_W'(CORE_TIMEOUT - 1);
            end else if (r_busy) begin
                if (w_rise || w_tmo) begin
                    r_busy <= 1'b0;
                end else begin
                    r_tmo <= r_tmo - 1'b1;
                end
            end
        end
    end

    // Error sources for this cycle
    always_comb begin
        w_err_set            = '0;
        w_err_set[ERR_FRAME] = w_frame_err;
        w_err_set[ERR_NOKEY] = w_drop;
        w_err_set[ERR_TMO]   = w_tmo;
    end

    // Sticky errors; a new error outranks a simultaneous clear
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & {3{!err_clr}}) | w_err_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gift_128_bus_ingress.sv
`default_nettype none
// ============================================================================
// Module      : tb_gift_128_bus_ingress
// Description : Scoreboard bench for gift_128_bus_ingress. Stimulus pushes the
//               expected load events; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gift_128_bus_ingress;

    logic         clk_i      = 1'b0;
    logic         reset      = 1'b1;
    logic         s_valid    = 1'b0;
    logic [31:0]  s_data     = '0;
    logic         s_is_key   = 1'b0;
    logic         s_last     = 1'b0;
    logic         err_clr    = 1'b0;
    logic         cov_manual = 1'b0;
    logic         cov_auto   = 1'b0;
    logic         cipher_out_valid;
    logic         s_ready;
    logic         key_input_valid;
    logic         data_input_valid;
    logic [127:0] key_input;
    logic [127:0] data_input;
    logic [2:0]   err_o;
    logic [15:0]  blk_cnt;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] exp_key[$];
    logic [143:0] exp_data[$];
    logic         m_key_loaded = 1'b0;
    logic [15:0]  m_cnt = '0;
    logic [2:0]   m_err = '0;
    logic [31:0]  blk_w[4];
    logic [143:0] mon_e;
    bit           auto_core = 1'b0;
    bit           emu_busy  = 1'b0;

    assign cipher_out_valid = cov_manual | cov_auto;

    gift_128_bus_ingress dut (
        .clk_i            (clk_i),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_is_key         (s_is_key),
        .s_last           (s_last),
        .key_input_valid  (key_input_valid),
        .key_input        (key_input),
        .data_input_valid (data_input_valid),
        .data_input       (data_input),
        .cipher_out_valid (cipher_out_valid),
        .err_o            (err_o),
        .err_clr          (err_clr),
        .blk_cnt          (blk_cnt)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Offer one word, holding it until a clock edge sees s_ready high
    task automatic send_word(input logic [31:0] d, input logic k, input logic l);
        logic rdy;
        int   n;
        s_valid = 1'b1; s_data = d; s_is_key = k; s_last = l; n = 0;
        do begin
            rdy = s_ready;
            step();
            n++;
        end while (!rdy && n < 600);
        if (!rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL handshake_timeout: s_ready 0 for %0d cycles, required 1", n);
        end
        s_valid = 1'b0;
    endtask

    // Send blk_w as one block and record what the core should see
    task automatic send_block(input logic k, input int gap);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            send_word(blk_w[i], k, (i == 3));
            v = {v[95:0], blk_w[i]};
            if (gap > 0 && i < 3) repeat ($urandom_range(0, gap)) step();
        end
        if (k) begin
            exp_key.push_back(v);
            m_key_loaded = 1'b1;
        end else if (m_key_loaded) begin
            m_cnt = m_cnt + 16'd1;
            exp_data.push_back({m_cnt, v});
        end else begin
            m_err[1] = 1'b1;
        end
    endtask

    // kind 0: last flagged on beat 1; kind 1: type flips on beat 2
    task automatic send_bad(input int kind, input logic k);
        send_word($urandom, k, 1'b0);
        if (kind == 0) begin
            send_word($urandom, k, 1'b1);
        end else begin
            send_word($urandom, k, 1'b0);
            send_word($urandom, !k, 1'b0);
        end
        m_err[0] = 1'b1;
    endtask

    task automatic rand_words();
        for (int i = 0; i < 4; i++) blk_w[i] = $urandom;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = '0;
        chk("err_clr", err_o, 0);
    endtask

    task automatic core_done();
        step(); cov_manual = 1'b1;
        step(); cov_manual = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_pulses"}, {key_input_valid, data_input_valid}, 0);
        chk({tag, "_key_input"}, key_input, 0);
        chk({tag, "_data_input"}, data_input, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_blk_cnt"}, blk_cnt, 0);
    endtask

    task automatic model_reset();
        chk("queues_empty_at_reset", exp_key.size() + exp_data.size(), 0);
        exp_key.delete(); exp_data.delete();
        m_key_loaded = 1'b0; m_cnt = '0; m_err = '0;
    endtask

    // Monitor: every load pulse must match the next expected event
    always @(negedge clk_i) begin
        if (!reset) begin
            if (key_input_valid) begin
                if (exp_key.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL key_pulse: unexpected pulse key_input=%h, required none", key_input);
                end else begin
                    chk("key_input", {16'h0, key_input}, {16'h0, exp_key.pop_front()});
                end
                chk("pulse_exclusive", data_input_valid, 0);
            end
            if (data_input_valid) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL data_pulse: unexpected pulse data_input=%h, required none", data_input);
                end else begin
                    mon_e = exp_data.pop_front();
                    chk("data_input", {16'h0, data_input}, {16'h0, mon_e[127:0]});
                    chk("blk_cnt", blk_cnt, mon_e[143:128]);
                end
            end
        end
    end

    // Core stand-in: answers each data pulse with a completion after a short delay
    initial forever begin
        @(negedge clk_i);
        if (auto_core && data_input_valid && !reset) begin
            emu_busy = 1'b1;
            repeat ($urandom_range(1, 12)) @(posedge clk_i);
            #1 cov_auto = 1'b1;
            @(posedge clk_i);
            #1 cov_auto = 1'b0;
            emu_busy = 1'b0;
        end
    end

    initial begin
        int n;
        repeat (3) step();
        chk_reset_outputs("reset");
        #2 reset = 1'b0;
        #1 chk("s_ready_before_clock", s_ready, 0);
        step();
        chk("s_ready_after_release", s_ready, 1);

        // Data with no key loaded is dropped
        rand_words();
        send_block(1'b0, 0);
        step();
        chk("nokey_err", err_o, 3'b010);
        chk("nokey_model_err", err_o, m_err);
        clear_err();

        // Framing errors
        send_bad(0, 1'b1);
        step();
        chk("frame_early_last", err_o, m_err);
        clear_err();
        send_bad(1, 1'b1);
        step();
        chk("frame_type_flip", err_o, m_err);
        clear_err();

        // Key load, pulse latency and settle gap
        blk_w[0] = 32'h01234567; blk_w[1] = 32'h89abcdef;
        blk_w[2] = 32'h01234567; blk_w[3] = 32'h89abcdef;
        send_block(1'b1, 0);
        chk("key_pulse_latency", key_input_valid, 1);
        chk("key_value", key_input, 128'h0123456789abcdef0123456789abcdef);
        chk("gap_ready_1", s_ready, 0);
        step();
        chk("key_pulse_single", key_input_valid, 0);
        chk("gap_ready_2", s_ready, 0);
        step();
        chk("gap_ready_end", s_ready, 1);

        // Same words as data, then a second block while the core is busy
        send_block(1'b0, 0);
        chk("data_pulse_latency", data_input_valid, 1);
        chk("data_ready_same_cycle", s_ready, 1);
        chk("data_first_cnt", blk_cnt, 1);
        rand_words();
        send_block(1'b0, 0);
        chk("pend_ready", s_ready, 0);
        chk("pend_no_pulse_0", data_input_valid, 0);
        step();
        chk("pend_no_pulse_1", data_input_valid, 0);
        step();
        cov_manual = 1'b1;
        chk("pend_no_pulse_at_rise", data_input_valid, 0);
        step();
        cov_manual = 1'b0;
        chk("pend_issue_after_rise", data_input_valid, 1);
        chk("pend_ready_after_issue", s_ready, 1);
        core_done();

        // Core never answers: watchdog fires exactly CORE_TIMEOUT cycles later
        rand_words();
        send_block(1'b0, 0);
        chk("tmo_issue", data_input_valid, 1);
        repeat (255) step();
        chk("tmo_not_early", err_o[2], 0);
        step();
        chk("tmo_exact", err_o[2], 1);
        m_err[2] = 1'b1;
        chk("tmo_err_vector", err_o, m_err);
        rand_words();
        send_block(1'b0, 0);
        chk("issue_after_tmo", data_input_valid, 1);
        core_done();
        clear_err();

        // Randomised mix of key, data and malformed blocks
        auto_core = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                send_bad($urandom_range(0, 1), 1'($urandom_range(0, 1)));
            end else begin
                rand_words();
                send_block(($urandom_range(0, 2) == 0), 2);
            end
            repeat ($urandom_range(0, 3)) step();
        end
        n = 0;
        while ((exp_key.size() != 0 || exp_data.size() != 0 || emu_busy) && n < 500) begin
            step();
            n++;
        end
        chk("random_drained", exp_key.size() + exp_data.size(), 0);
        chk("random_err", err_o, m_err);
        auto_core = 1'b0;
        step();
        clear_err();

        // Reset in the middle of a block
        rand_words();
        send_word(blk_w[0], 1'b1, 1'b0);
        send_word(blk_w[1], 1'b1, 1'b0);
        s_valid = 1'b1; s_data = blk_w[2]; s_is_key = 1'b1; s_last = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_outputs("mid_block_reset");
        s_valid = 1'b0;
        model_reset();
        #2 reset = 1'b0;
        step();
        chk("ready_after_mid_block_reset", s_ready, 1);

        // Reset while an encryption is in flight
        rand_words();
        send_block(1'b1, 0);
        repeat (3) step();
        rand_words();
        send_block(1'b0, 0);
        step();
        #2 reset = 1'b1;
        #1 chk_reset_outputs("busy_reset");
        model_reset();
        #2 reset = 1'b0;
        step();

        // Fresh key and data after reset
        rand_words();
        send_block(1'b1, 0);
        repeat (3) step();
        rand_words();
        send_block(1'b0, 0);
        chk("blk_cnt_after_reset", blk_cnt, 1);
        core_done();
        step();
        chk("final_drained", exp_key.size() + exp_data.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
